imem_loader: RTL and testbench

//   Boot-time writer for the instruction ROM that the CPU fetches from at PC.
//   - Accepts a framed byte stream on a valid/ready port.
//   - Packs the bytes big-endian into 32-bit words and writes them to the ROM write port.
//   - Holds the CPU in reset until a complete frame with a correct checksum has been loaded.
//   - Frame format: CNT_HI, CNT_LO (16-bit word count N), then 4*N data bytes, then 1 XOR checksum byte.

---
 rtl/imem_loader.sv | 183 ++++++++++++++++++
 tb/tb_imem_loader.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot loader: unpacks a framed, XOR-checksummed byte stream into big-endian
// 32-bit instruction ROM writes and releases the CPU reset once a frame verifies.
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 64,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [7:0]            i_byte,
    input  logic                  i_byte_valid,
    output logic                  o_byte_ready,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [31:0]           o_wr_data,
    output logic                  o_cpu_rst_n,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);
    localparam logic [15:0]           MAX_N     = 16'(MAX_WORDS);

    state_e                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [15:0]           idx_q, idx_d;
    logic [1:0]            pos_q, pos_d;
    logic [23:0]           word_q, word_d;
    logic [7:0]            csum_q, csum_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]           wr_data_q, wr_data_d;
    logic                  ready_q, busy_q, done_q, error_q, cpu_rst_n_q;
    logic                  in_frame_d;

    logic                  accept;
    logic [15:0]           n_full;
    logic [15:0]           idx_inc;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can
        // leave it unassigned and infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        pos_d     = pos_q;
        word_d    = word_q;
        csum_d    = csum_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        accept  = i_byte_valid && ready_q;
        n_full  = {cnt_q[15:8], i_byte};
        idx_inc = idx_q + 16'd1;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_start) begin
                    state_d = S_CNT_HI;
                    cnt_d   = '0;
                    idx_d   = '0;
                    pos_d   = '0;
                    csum_d  = '0;
                    addr_d  = BASE;
                end
            end
            S_CNT_HI: begin
                if (accept) begin
                    cnt_d   = {i_byte, 8'h00};
                    csum_d  = csum_q ^ i_byte;
                    state_d = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (accept) begin
                    cnt_d  = n_full;
                    csum_d = csum_q ^ i_byte;
                    if (n_full > MAX_N) begin
                        state_d = S_ERR;
                    end else if (n_full == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ i_byte;
                    pos_d  = pos_q + 2'd1;
                    word_d = {word_q[15:0], i_byte};
                    // The write strobe lands in the cycle after the 4th byte,
                    // while the stream keeps flowing into the next word.
                    if (pos_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = {word_q, i_byte};
                        wr_addr_d = addr_q;
                        addr_d    = addr_q + WORD_STEP;
                        idx_d     = idx_inc;
                        if (idx_inc == cnt_q) begin
                            state_d = S_CHK;
                        end
                    end
                end
            end
            S_CHK: begin
                if (accept) begin
                    state_d = (i_byte == csum_q) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_frame_d = (state_d == S_CNT_HI) || (state_d == S_CNT_LO) ||
                     (state_d == S_DATA)   || (state_d == S_CHK);
    end

    // Status outputs are registered copies decoded from the next state, so
    // they line up exactly with the state they describe.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples pre-edge values regardless of statement order.
        if (i_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            pos_q       <= '0;
            word_q      <= '0;
            csum_q      <= '0;
            addr_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pos_q       <= pos_d;
            word_q      <= word_d;
            csum_q      <= csum_d;
            addr_q      <= addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            ready_q     <= in_frame_d;
            busy_q      <= in_frame_d;
            done_q      <= (state_d == S_DONE);
            error_q     <= (state_d == S_ERR);
            cpu_rst_n_q <= (state_d == S_DONE);
        end
    end

    assign o_byte_ready = ready_q;
    assign o_wr_en      = wr_en_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_cpu_rst_n  = cpu_rst_n_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: streams hand-built frames and compares the
// captured ROM writes and status outputs against hand-computed values.
module tb_imem_loader;

    localparam int ADDR_WIDTH = 8;

    typedef logic [7:0] byte_q_t[$];

    logic                  i_clk = 1'b0;
    logic                  i_rst = 1'b0;
    logic                  i_start = 1'b0;
    logic [7:0]            i_byte = 8'h00;
    logic                  i_byte_valid = 1'b0;
    logic                  o_byte_ready;
    logic                  o_wr_en;
    logic [ADDR_WIDTH-1:0] o_wr_addr;
    logic [31:0]           o_wr_data;
    logic                  o_cpu_rst_n;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_error;

    int checks = 0;
    int errors = 0;
    int done_writes = 0;

    logic [ADDR_WIDTH-1:0] log_addr[$];
    logic [31:0]           log_data[$];

    imem_loader #(.ADDR_WIDTH(ADDR_WIDTH), .MAX_WORDS(64), .BASE_ADDR(0)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .o_byte_ready (o_byte_ready),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_cpu_rst_n  (o_cpu_rst_n),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_wr_en) begin
            log_addr.push_back(o_wr_addr);
            log_data.push_back(o_wr_data);
        end
        if (o_wr_en && o_done) done_writes++;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int  n;
        bit  ok;
        i_byte_valid = 1'b0;
        if (max_gap > 0) begin
            n = $urandom_range(0, max_gap);
            repeat (n) tick();
        end
        i_byte       = b;
        i_byte_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 16 && !ok; t++) begin
            @(negedge i_clk);
            ok = o_byte_ready;
            @(posedge i_clk);
            #1;
        end
        i_byte_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL handshake_timeout byte=%02h ready never seen", b);
        end
    endtask

    task automatic send_frame(input byte_q_t f, input int max_gap);
        foreach (f[i]) send_byte(f[i], max_gap);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    // Frame used by several scenarios; XOR over 00 02 and the eight data bytes is 02.
    function automatic byte_q_t frame_two_words(input logic [7:0] csum);
        byte_q_t f;
        f = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        f.push_back(csum);
        return f;
    endfunction

    task automatic check_two_words(input string tag);
        checks++;
        if (log_addr.size() !== 2) begin
            errors++;
            $display("FAIL %s_write_count got %0d want 2", tag, log_addr.size());
        end else begin
            checks++;
            if (log_addr[0] !== 8'h00 || log_data[0] !== 32'h12345678) begin
                errors++;
                $display("FAIL %s_write0 got %02h/%08h want 00/12345678", tag, log_addr[0], log_data[0]);
            end
            checks++;
            if (log_addr[1] !== 8'h04 || log_data[1] !== 32'h9ABCDEF0) begin
                errors++;
                $display("FAIL %s_write1 got %02h/%08h want 04/9abcdef0", tag, log_addr[1], log_data[1]);
            end
        end
    endtask

    task automatic test_reset();
        logic [46:0] outs;
        i_rst = 1'b1;
        tick();
        tick();
        outs = {o_byte_ready, o_wr_en, o_wr_addr, o_wr_data, o_cpu_rst_n, o_busy, o_done, o_error};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", outs);
        end
        i_rst = 1'b0;
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_byte_ready !== 1'b0 || o_cpu_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b ready=%b cpu=%b want 0 0 0", o_busy, o_byte_ready, o_cpu_rst_n);
        end
    endtask

    task automatic test_good_frame();
        clear_log();
        pulse_start();
        checks++;
        if (o_busy !== 1'b1 || o_byte_ready !== 1'b1 || o_cpu_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL good_start got busy=%b ready=%b cpu=%b want 1 1 0", o_busy, o_byte_ready, o_cpu_rst_n);
        end
        send_frame(frame_two_words(8'h02), 0);
        check_two_words("good");
        checks++;
        if (o_done !== 1'b1 || o_cpu_rst_n !== 1'b1 || o_error !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL good_status got done=%b cpu=%b err=%b busy=%b want 1 1 0 0",
                     o_done, o_cpu_rst_n, o_error, o_busy);
        end
    endtask

    task automatic test_bad_csum();
        clear_log();
        pulse_start();
        checks++;
        if (o_cpu_rst_n !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL restart_from_done got cpu=%b done=%b want 0 0", o_cpu_rst_n, o_done);
        end
        send_frame(frame_two_words(8'hFF), 0);
        check_two_words("badcsum");
        checks++;
        if (o_error !== 1'b1 || o_done !== 1'b0 || o_cpu_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL badcsum_status got err=%b done=%b cpu=%b want 1 0 0", o_error, o_done, o_cpu_rst_n);
        end
    endtask

    task automatic test_count_too_big();
        byte_q_t f;
        clear_log();
        pulse_start();
        checks++;
        if (o_error !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_from_err got err=%b busy=%b want 0 1", o_error, o_busy);
        end
        f = '{8'h00, 8'h41};
        send_frame(f, 0);
        checks++;
        if (o_error !== 1'b1 || o_busy !== 1'b0 || o_byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL bigcount_status got err=%b busy=%b ready=%b want 1 0 0", o_error, o_busy, o_byte_ready);
        end
        i_byte = 8'h55;
        i_byte_valid = 1'b1;
        repeat (4) tick();
        i_byte_valid = 1'b0;
        checks++;
        if (log_addr.size() !== 0 || o_error !== 1'b1) begin
            errors++;
            $display("FAIL bigcount_writes got %0d writes err=%b want 0 writes err=1", log_addr.size(), o_error);
        end
    endtask

    task automatic test_zero_count();
        byte_q_t f;
        clear_log();
        pulse_start();
        f = '{8'h00, 8'h00, 8'h00};
        send_frame(f, 0);
        checks++;
        if (o_done !== 1'b1 || o_cpu_rst_n !== 1'b1 || log_addr.size() !== 0) begin
            errors++;
            $display("FAIL zerocount got done=%b cpu=%b writes=%0d want 1 1 0", o_done, o_cpu_rst_n, log_addr.size());
        end
    endtask

    task automatic test_gaps_and_start();
        byte_q_t f;
        f = frame_two_words(8'h02);
        clear_log();
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(f[i], 3);
        pulse_start();
        checks++;
        if (o_busy !== 1'b1 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL start_while_busy got busy=%b done=%b want 1 0", o_busy, o_done);
        end
        for (int i = 5; i < f.size(); i++) send_byte(f[i], 3);
        check_two_words("gaps");
        checks++;
        if (o_done !== 1'b1 || o_cpu_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL gaps_status got done=%b cpu=%b want 1 1", o_done, o_cpu_rst_n);
        end
    endtask

    task automatic test_reset_mid_frame();
        byte_q_t f;
        logic [46:0] outs;
        f = frame_two_words(8'h02);
        clear_log();
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(f[i], 0);
        i_rst = 1'b1;
        tick();
        outs = {o_byte_ready, o_wr_en, o_wr_addr, o_wr_data, o_cpu_rst_n, o_busy, o_done, o_error};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got %h want 0", outs);
        end
        i_rst = 1'b0;
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_cpu_rst_n !== 1'b0 || log_addr.size() !== 1) begin
            errors++;
            $display("FAIL midreset_idle got busy=%b cpu=%b writes=%0d want 0 0 1", o_busy, o_cpu_rst_n, log_addr.size());
        end
        clear_log();
        pulse_start();
        send_frame(f, 0);
        check_two_words("afterreset");
        checks++;
        if (o_done !== 1'b1 || o_cpu_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL afterreset_status got done=%b cpu=%b want 1 1", o_done, o_cpu_rst_n);
        end
    endtask

    task automatic test_back_to_back();
        byte_q_t f;
        // 00^01 ^ AA^BB^CC^DD = 01
        f = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};
        clear_log();
        pulse_start();
        send_frame(f, 0);
        checks++;
        if (log_addr.size() !== 1 || o_done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_status got writes=%0d done=%b want 1 1", log_addr.size(), o_done);
        end else begin
            checks++;
            if (log_addr[0] !== 8'h00 || log_data[0] !== 32'hAABBCCDD) begin
                errors++;
                $display("FAIL b2b_write got %02h/%08h want 00/aabbccdd", log_addr[0], log_data[0]);
            end
        end
    endtask

    task automatic test_max_count();
        byte_q_t f;
        int bad;
        // Word i is four copies of byte i, so the data XOR is 0 and csum = 00^40.
        f = '{8'h00, 8'h40};
        for (int i = 0; i < 64; i++) repeat (4) f.push_back(8'(i));
        f.push_back(8'h40);
        clear_log();
        pulse_start();
        send_frame(f, 0);
        checks++;
        if (log_addr.size() !== 64 || o_done !== 1'b1) begin
            errors++;
            $display("FAIL maxcount_status got writes=%0d done=%b want 64 1", log_addr.size(), o_done);
        end else begin
            bad = 0;
            for (int i = 0; i < 64; i++) begin
                if (log_addr[i] !== 8'(4 * i) || log_data[i] !== {4{8'(i)}}) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL maxcount_words got %0d bad words want 0 (last %02h/%08h)", bad, log_addr[63], log_data[63]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_count_too_big();
        test_zero_count();
        test_gaps_and_start();
        test_reset_mid_frame();
        test_back_to_back();
        test_max_count();
        checks++;
        if (done_writes !== 0) begin
            errors++;
            $display("FAIL write_in_done got %0d want 0", done_writes);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
